// File: rtl/prog_loader.sv
// Program-memory loader: parses SYNC/LEN/words/checksum frames from a byte stream,
// writes each word to instruction memory and holds the core until a frame checks good.
module prog_loader #(
    parameter logic [7:0]  SYNC_BYTE = 8'hA5,
    parameter logic [7:0]  BASE_ADDR = 8'h00,
    parameter int unsigned TIMEOUT   = 1000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    input  logic [7:0]  in_data,
    output logic        in_ready,
    output logic        mem_we,
    output logic [7:0]  mem_addr,
    output logic [15:0] mem_wdata,
    output logic        core_hold,
    output logic        done,
    output logic        err
);

    typedef enum logic [2:0] {
        StIdle,
        StLen,
        StHi,
        StLo,
        StWrite,
        StCsum,
        StDone,
        StErr
    } state_e;

    state_e     state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic [7:0] idx_q, idx_d;
    logic [7:0] csum_q, csum_d;
    logic [7:0] hi_q, hi_d;
    logic [7:0] lo_q, lo_d;
    logic [9:0] tmo_q, tmo_d;
    logic       hold_q, hold_d;
    logic       err_q, err_d;
    logic       accept;
    logic       tmo_active;
    logic       tmo_hit;

    assign in_ready   = (state_q != StWrite);
    assign accept     = in_valid & in_ready;
    assign tmo_active = (state_q == StLen) || (state_q == StHi) ||
                        (state_q == StLo)  || (state_q == StCsum);
    assign tmo_hit    = tmo_active && !accept && (tmo_q == 10'(TIMEOUT - 1));

    assign core_hold = hold_q;
    assign err       = err_q;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        idx_d     = idx_q;
        csum_d    = csum_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        hold_d    = hold_q;
        err_d     = err_q;
        mem_we    = 1'b0;
        mem_addr  = 8'h00;
        mem_wdata = 16'h0000;
        done      = 1'b0;

        // Idle-gap counter only runs while waiting for a byte mid-frame.
        if (accept || !tmo_active) begin
            tmo_d = 10'd0;
        end else begin
            tmo_d = tmo_q + 10'd1;
        end

        unique case (state_q)
            StIdle: begin
                if (accept && (in_data == SYNC_BYTE)) begin
                    state_d = StLen;
                    err_d   = 1'b0;
                    hold_d  = 1'b1;
                end
            end
            StLen: begin
                if (accept) begin
                    cnt_d   = in_data;
                    csum_d  = in_data;
                    idx_d   = 8'h00;
                    state_d = (in_data == 8'h00) ? StCsum : StHi;
                end
            end
            StHi: begin
                if (accept) begin
                    hi_d    = in_data;
                    csum_d  = csum_q ^ in_data;
                    state_d = StLo;
                end
            end
            StLo: begin
                if (accept) begin
                    lo_d    = in_data;
                    csum_d  = csum_q ^ in_data;
                    state_d = StWrite;
                end
            end
            StWrite: begin
                mem_we    = 1'b1;
                mem_addr  = BASE_ADDR + idx_q;
                mem_wdata = {hi_q, lo_q};
                idx_d     = idx_q + 8'd1;
                state_d   = (({1'b0, idx_q} + 9'd1) < {1'b0, cnt_q}) ? StHi : StCsum;
            end
            StCsum: begin
                if (accept) begin
                    state_d = (in_data == csum_q) ? StDone : StErr;
                end
            end
            StDone: begin
                done    = 1'b1;
                hold_d  = 1'b0;
                state_d = StIdle;
            end
            StErr: begin
                err_d   = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase

        if (tmo_hit) begin
            state_d = StErr;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= 8'h00;
            idx_q   <= 8'h00;
            csum_q  <= 8'h00;
            hi_q    <= 8'h00;
            lo_q    <= 8'h00;
            tmo_q   <= 10'd0;
            hold_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            csum_q  <= csum_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            tmo_q   <= tmo_d;
            hold_q  <= hold_d;
            err_q   <= err_d;
        end
    end

endmodule
